// File: rtl/jt12_lfo_gen_if.sv
// ============================================================================
// Module      : jt12_lfo_gen_if
// Description : Control/data bundle between slot sequencer and the LFO stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jt12_lfo_gen_if;
  logic       clk_en;
  logic       zero;
  logic       lfo_en;
  logic [2:0] lfo_freq;
  logic [1:0] ams_I;
  logic [6:0] lfo_mod;
  logic [7:0] am_out;

  modport master (
    output clk_en, zero, lfo_en, lfo_freq, ams_I,
    input  lfo_mod, am_out
  );

  modport slave (
    input  clk_en, zero, lfo_en, lfo_freq, ams_I,
    output lfo_mod, am_out
  );
endinterface

`default_nettype wire

// File: rtl/jt12_lfo_gen.sv
// ============================================================================
// Module      : jt12_lfo_gen
// Description : LFO divider producing the vibrato position and per-slot AM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt12_lfo_gen #(
  parameter int CNTW = 7
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  jt12_lfo_gen_if.slave     bus
);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_limit_m1;
  logic [6:0]      r_lfo;
  logic [7:0]      r_am;
  logic [5:0]      w_tri;
  logic [7:0]      w_am;

  // Terminal count is limit-1 so the step lands exactly every limit pulses
  always_comb begin
    w_limit_m1 = CNTW'(107);
    case (bus.lfo_freq)
      3'd0:    w_limit_m1 = CNTW'(107);
      3'd1:    w_limit_m1 = CNTW'(76);
      3'd2:    w_limit_m1 = CNTW'(70);
      3'd3:    w_limit_m1 = CNTW'(66);
      3'd4:    w_limit_m1 = CNTW'(61);
      3'd5:    w_limit_m1 = CNTW'(43);
      3'd6:    w_limit_m1 = CNTW'(7);
      default: w_limit_m1 = CNTW'(4);
    endcase
  end

  // >= lets a rate change below the current count step immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_lfo <= '0;
    end else if (bus.clk_en && bus.zero) begin
      if (!bus.lfo_en) begin
        r_cnt <= '0;
        r_lfo <= '0;
      end else if (r_cnt >= w_limit_m1) begin
        r_cnt <= '0;
        r_lfo <= r_lfo + 7'd1;
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  always_comb begin
    w_tri = r_lfo[6] ? ~r_lfo[5:0] : r_lfo[5:0];
    w_am  = 8'd0;
    case (bus.ams_I)
      2'd0:    w_am = 8'd0;
      2'd1:    w_am = {5'd0, w_tri[5:3]};
      2'd2:    w_am = {3'd0, w_tri[5:1]};
      default: w_am = {1'b0, w_tri, 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_am <= 8'd0;
    end else if (bus.clk_en) begin
      r_am <= w_am;
    end
  end

  assign bus.lfo_mod = r_lfo;
  assign bus.am_out  = r_am;

endmodule

`default_nettype wire

// File: tb/tb_jt12_lfo_gen.sv
// ============================================================================
// Module      : tb_jt12_lfo_gen
// Description : Randomized and directed self-checking bench for jt12_lfo_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt12_lfo_gen;

  logic clk;
  logic rst_n;
  jt12_lfo_gen_if bus();

  jt12_lfo_gen #(.CNTW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: pulses since last step, LFO position, AM output
  int m_cnt;
  int m_lfo;
  int m_am;
  int lim_tab [8] = '{108, 77, 71, 67, 62, 44, 8, 5};

  function automatic int am_ref(input int pos, input int ams);
    int tri_v;
    tri_v = (pos < 64) ? pos : 127 - pos;
    case (ams)
      0:       return 0;
      1:       return tri_v / 8;
      2:       return tri_v / 2;
      default: return tri_v * 2;
    endcase
  endfunction

  // Drive one clock's worth of inputs from a negedge, return at next negedge
  task automatic cyc(input bit ce, input bit z, input bit en,
                     input int f, input int a);
    int nam;
    bus.clk_en   = ce;
    bus.zero     = z;
    bus.lfo_en   = en;
    bus.lfo_freq = 3'(f);
    bus.ams_I    = 2'(a);
    @(posedge clk);
    if (ce) begin
      nam = am_ref(m_lfo, a);
      if (z) begin
        if (!en) begin
          m_cnt = 0;
          m_lfo = 0;
        end else if (m_cnt + 1 >= lim_tab[f]) begin
          m_cnt = 0;
          m_lfo = (m_lfo + 1) % 128;
        end else begin
          m_cnt++;
        end
      end
      m_am = nam;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.clk_en = 1'b0;
    bus.zero   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt = 0;
    m_lfo = 0;
    m_am  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Step the LFO n times at the fastest rate with back-to-back zero cycles
  task automatic advance(input int n);
    for (int i = 0; i < 5 * n; i++) cyc(1, 1, 1, 7, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clk_en = 1'b0; bus.zero = 1'b0; bus.lfo_en = 1'b0;
    bus.lfo_freq = 3'd0; bus.ams_I = 2'd0;
    m_cnt = 0; m_lfo = 0; m_am = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.lfo_mod !== 7'd0 || bus.am_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state lfo_mod=%0d am_out=%0d expected 0/0", bus.lfo_mod, bus.am_out);
    end
    rst_n = 1'b1;
    // Asynchronous reset mid-count with lfo_mod=37
    advance(37);
    cyc(1, 1, 1, 7, 0);
    cyc(1, 1, 1, 7, 0);
    cyc(1, 0, 1, 7, 3);
    n_checks++;
    if (bus.lfo_mod !== 7'd37 || bus.am_out !== 8'd74) begin
      n_fail++;
      $display("FAIL pre_reset lfo_mod=%0d am_out=%0d expected 37/74", bus.lfo_mod, bus.am_out);
    end
    bus.clk_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.lfo_mod !== 7'd0 || bus.am_out !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset lfo_mod=%0d am_out=%0d expected 0/0", bus.lfo_mod, bus.am_out);
    end
    m_cnt = 0; m_lfo = 0; m_am = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // Counter must restart from zero: four pulses no step, fifth steps
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 7, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_cnt_cleared lfo_mod=%0d expected 0", bus.lfo_mod);
    end
    cyc(1, 1, 1, 7, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd1) begin
      n_fail++;
      $display("FAIL reset_first_step lfo_mod=%0d expected 1", bus.lfo_mod);
    end
  endtask

  task automatic test_fast_wrap();
    do_reset();
    for (int p = 1; p <= 640; p++) begin
      for (int k = 0; k < 24; k++) cyc(1, (k == 0), 1, 7, 0);
      n_checks++;
      if (bus.lfo_mod !== 7'(m_lfo)) begin
        n_fail++;
        $display("FAIL wrap_track pulse=%0d lfo_mod=%0d expected %0d", p, bus.lfo_mod, m_lfo);
      end
      if (p == 5) begin
        n_checks++;
        if (bus.lfo_mod !== 7'd1) begin
          n_fail++;
          $display("FAIL wrap_first_step lfo_mod=%0d expected 1", bus.lfo_mod);
        end
      end
      if (p == 635) begin
        n_checks++;
        if (bus.lfo_mod !== 7'd127) begin
          n_fail++;
          $display("FAIL wrap_top lfo_mod=%0d expected 127", bus.lfo_mod);
        end
      end
    end
    n_checks++;
    if (bus.lfo_mod !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_final lfo_mod=%0d expected 0", bus.lfo_mod);
    end
  endtask

  task automatic test_rate_change();
    do_reset();
    for (int i = 0; i < 50; i++) cyc(1, 1, 1, 0, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd0) begin
      n_fail++;
      $display("FAIL rate_pre lfo_mod=%0d expected 0", bus.lfo_mod);
    end
    cyc(1, 1, 1, 6, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd1) begin
      n_fail++;
      $display("FAIL rate_immediate lfo_mod=%0d expected 1", bus.lfo_mod);
    end
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 6, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd1) begin
      n_fail++;
      $display("FAIL rate_hold lfo_mod=%0d expected 1", bus.lfo_mod);
    end
    cyc(1, 1, 1, 6, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd2) begin
      n_fail++;
      $display("FAIL rate_period8 lfo_mod=%0d expected 2", bus.lfo_mod);
    end
  endtask

  task automatic test_am();
    int exp_50 [4] = '{0, 5, 23, 94};
    do_reset();
    advance(63);
    cyc(1, 0, 1, 7, 3);
    n_checks++;
    if (bus.am_out !== 8'd126) begin
      n_fail++;
      $display("FAIL am_apex_3f am_out=%0d expected 126", bus.am_out);
    end
    advance(1);
    cyc(1, 0, 1, 7, 3);
    n_checks++;
    if (bus.lfo_mod !== 7'h40 || bus.am_out !== 8'd126) begin
      n_fail++;
      $display("FAIL am_apex_40 lfo_mod=%0d am_out=%0d expected 64/126", bus.lfo_mod, bus.am_out);
    end
    advance(16);
    for (int a = 0; a < 4; a++) begin
      cyc(1, 0, 1, 7, a);
      n_checks++;
      if (bus.am_out !== 8'(exp_50[a])) begin
        n_fail++;
        $display("FAIL am_ams%0d am_out=%0d expected %0d", a, bus.am_out, exp_50[a]);
      end
    end
    advance(47);
    cyc(1, 0, 1, 7, 3);
    n_checks++;
    if (bus.lfo_mod !== 7'h7f || bus.am_out !== 8'd0) begin
      n_fail++;
      $display("FAIL am_bottom lfo_mod=%0d am_out=%0d expected 127/0", bus.lfo_mod, bus.am_out);
    end
  endtask

  task automatic test_disable_and_hold();
    logic [6:0] h_lfo;
    logic [7:0] h_am;
    do_reset();
    advance(20);
    cyc(1, 1, 0, 7, 3);
    n_checks++;
    if (bus.lfo_mod !== 7'd0 || bus.am_out !== 8'd40) begin
      n_fail++;
      $display("FAIL disable_step lfo_mod=%0d am_out=%0d expected 0/40", bus.lfo_mod, bus.am_out);
    end
    for (int i = 0; i < 10; i++) cyc(1, (i % 2 == 0), 0, 7, 3);
    n_checks++;
    if (bus.lfo_mod !== 7'd0 || bus.am_out !== 8'd0) begin
      n_fail++;
      $display("FAIL disable_stays lfo_mod=%0d am_out=%0d expected 0/0", bus.lfo_mod, bus.am_out);
    end
    advance(10);
    cyc(1, 1, 1, 7, 0);
    cyc(1, 1, 1, 7, 3);
    h_lfo = bus.lfo_mod;
    h_am  = bus.am_out;
    for (int i = 0; i < 100; i++) begin
      cyc(0, (i % 24 == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom_range(0, 3));
      n_checks++;
      if (bus.lfo_mod !== 7'd10 || bus.am_out !== 8'd20) begin
        n_fail++;
        $display("FAIL clk_en_hold i=%0d lfo_mod=%0d am_out=%0d expected 10/20 (had %0d/%0d)",
                 i, bus.lfo_mod, bus.am_out, h_lfo, h_am);
      end
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 7, 0);
    n_checks++;
    if (bus.lfo_mod !== 7'd11) begin
      n_fail++;
      $display("FAIL clk_en_resume lfo_mod=%0d expected 11", bus.lfo_mod);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) != 0), $urandom_range(0, 7), $urandom_range(0, 3));
      n_checks++;
      if (bus.lfo_mod !== 7'(m_lfo) || bus.am_out !== 8'(m_am)) begin
        n_fail++;
        $display("FAIL random i=%0d lfo_mod=%0d am_out=%0d expected %0d/%0d",
                 i, bus.lfo_mod, bus.am_out, m_lfo, m_am);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_wrap();
    test_rate_change();
    test_am();
    test_disable_and_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
